// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter that drains an asynchronous FIFO read port: pops a word whenever
// the FIFO is non-empty and the line is free, then sends start, data LSB first, optional parity, stop.
module uart_tx_fifo_drain #(
    parameter int D_SIZE = 8,
    parameter int CNT_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [D_SIZE-1:0] i_r_data,
    input  logic              i_empty,
    input  logic              i_par_en,
    input  logic              i_par_typ,
    output logic              o_r_inc,
    output logic              o_tx,
    output logic              o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(D_SIZE - 1);

    // Parity of a word; odd=1 inverts the even-parity result.
    function automatic logic parity_bit(input logic [D_SIZE-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

    state_t            state_r;
    logic [D_SIZE-1:0] shift_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              par_en_r;
    logic              par_r;
    logic              tx_r;
    logic              busy_r;
    logic              r_inc_r;
    logic              capture_s;

    // A new word may be taken from idle or from the stop cycle, which gives gap-free frames.
    assign capture_s = ((state_r == ST_IDLE) || (state_r == ST_STOP)) && !i_empty;

    // Frame sequencer; every output is a flop so the line never glitches.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            par_en_r <= 1'b0;
            par_r    <= 1'b0;
            tx_r     <= 1'b1;
            busy_r   <= 1'b0;
            r_inc_r  <= 1'b0;
        end else begin
            r_inc_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_STOP: begin
                    if (capture_s) begin
                        state_r  <= ST_START;
                        shift_r  <= i_r_data;
                        par_en_r <= i_par_en;
                        par_r    <= parity_bit(i_r_data, i_par_typ);
                        cnt_r    <= '0;
                        tx_r     <= 1'b0;
                        busy_r   <= 1'b1;
                        r_inc_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        tx_r    <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_START: begin
                    state_r <= ST_DATA;
                    tx_r    <= shift_r[0];
                    shift_r <= {1'b0, shift_r[D_SIZE-1:1]};
                    cnt_r   <= '0;
                end
                ST_DATA: begin
                    if (cnt_r == LAST_BIT) begin
                        if (par_en_r) begin
                            state_r <= ST_PARITY;
                            tx_r    <= par_r;
                        end else begin
                            state_r <= ST_STOP;
                            tx_r    <= 1'b1;
                        end
                    end else begin
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[D_SIZE-1:1]};
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    state_r <= ST_STOP;
                    tx_r    <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tx    = tx_r;
    assign o_busy  = busy_r;
    assign o_r_inc = r_inc_r;

endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Directed bench for uart_tx_fifo_drain with a small FIFO model driving the read port;
// outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo_drain;

    logic       i_clk = 1'b0;
    logic       i_rstn = 1'b0;
    logic [7:0] i_r_data;
    logic       i_empty;
    logic       i_par_en = 1'b0;
    logic       i_par_typ = 1'b0;
    logic       o_r_inc;
    logic       o_tx;
    logic       o_busy;

    logic [7:0] mem [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    int total = 0;
    int bad = 0;

    uart_tx_fifo_drain #(.D_SIZE(8), .CNT_W(4)) dut (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_r_data (i_r_data),
        .i_empty  (i_empty),
        .i_par_en (i_par_en),
        .i_par_typ(i_par_typ),
        .o_r_inc  (o_r_inc),
        .o_tx     (o_tx),
        .o_busy   (o_busy)
    );

    always #5 i_clk = ~i_clk;

    assign i_empty  = (wr_ptr == rd_ptr);
    assign i_r_data = mem[rd_ptr];

    always @(posedge i_clk) begin
        if (o_r_inc) rd_ptr <= rd_ptr + 4'd1;
    end

    task automatic push(input logic [7:0] d);
        mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    task automatic test_reset;
        int n;
        push(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge i_clk);
            total++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_r_inc !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cyc %0d: tx=%b busy=%b r_inc=%b, want 1 0 0", i, o_tx, o_busy, o_r_inc);
            end
        end
        i_rstn = 1'b1;
        @(negedge i_clk);
        total++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1 || o_r_inc !== 1'b1) begin
            bad++;
            $display("FAIL reset_release: tx=%b busy=%b r_inc=%b, want 0 1 1", o_tx, o_busy, o_r_inc);
        end
        n = 0;
        while (o_busy === 1'b1 && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        total++;
        if (o_busy !== 1'b0 || o_tx !== 1'b1 || i_empty !== 1'b1) begin
            bad++;
            $display("FAIL reset_drain: busy=%b tx=%b empty=%b after %0d cycles, want 0 1 1", o_busy, o_tx, i_empty, n);
        end
    endtask

    task automatic test_frame(input logic [7:0] d, input logic pe, input logic pt, input string name);
        logic exp_tx [0:10];
        int len;
        len = pe ? 11 : 10;
        exp_tx[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_tx[1+k] = d[k];
        if (pe) begin
            exp_tx[9]  = (^d) ^ pt;
            exp_tx[10] = 1'b1;
        end else begin
            exp_tx[9]  = 1'b1;
            exp_tx[10] = 1'b1;
        end
        i_par_en  = pe;
        i_par_typ = pt;
        push(d);
        for (int i = 0; i < len; i++) begin
            @(negedge i_clk);
            total++;
            if (o_tx !== exp_tx[i] || o_busy !== 1'b1 || o_r_inc !== (i == 0)) begin
                bad++;
                $display("FAIL %s cyc %0d: tx=%b busy=%b r_inc=%b, want tx=%b busy=1 r_inc=%b",
                         name, i, o_tx, o_busy, o_r_inc, exp_tx[i], (i == 0));
            end
        end
        @(negedge i_clk);
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_r_inc !== 1'b0 || i_empty !== 1'b1) begin
            bad++;
            $display("FAIL %s idle: tx=%b busy=%b r_inc=%b empty=%b, want 1 0 0 1", name, o_tx, o_busy, o_r_inc, i_empty);
        end
        i_par_en  = 1'b0;
        i_par_typ = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [7:0] words [0:2];
        logic exp_tx [0:29];
        int pulses;
        words[0] = 8'h01;
        words[1] = 8'hFF;
        words[2] = 8'h80;
        for (int w = 0; w < 3; w++) begin
            exp_tx[w*10] = 1'b0;
            for (int k = 0; k < 8; k++) exp_tx[w*10+1+k] = words[w][k];
            exp_tx[w*10+9] = 1'b1;
        end
        pulses = 0;
        push(words[0]);
        push(words[1]);
        push(words[2]);
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (o_r_inc === 1'b1) pulses++;
            total++;
            if (o_tx !== exp_tx[i] || o_busy !== 1'b1 || o_r_inc !== ((i % 10) == 0)) begin
                bad++;
                $display("FAIL b2b cyc %0d: tx=%b busy=%b r_inc=%b, want tx=%b busy=1 r_inc=%b",
                         i, o_tx, o_busy, o_r_inc, exp_tx[i], ((i % 10) == 0));
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d, want 3", pulses);
        end
        @(negedge i_clk);
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || i_empty !== 1'b1) begin
            bad++;
            $display("FAIL b2b_idle: tx=%b busy=%b empty=%b, want 1 0 1", o_tx, o_busy, i_empty);
        end
    endtask

    task automatic test_cfg_change;
        logic [7:0] d0;
        logic [7:0] d1;
        logic exp_tx [0:20];
        d0 = 8'h3C;
        d1 = 8'h5B;
        exp_tx[0] = 1'b0;
        for (int k = 0; k < 8; k++) exp_tx[1+k] = d0[k];
        exp_tx[9]  = 1'b1;
        exp_tx[10] = 1'b0;
        for (int k = 0; k < 8; k++) exp_tx[11+k] = d1[k];
        exp_tx[19] = ^d1;
        exp_tx[20] = 1'b1;
        i_par_en  = 1'b0;
        i_par_typ = 1'b0;
        push(d0);
        for (int i = 0; i < 21; i++) begin
            @(negedge i_clk);
            total++;
            if (o_tx !== exp_tx[i] || o_busy !== 1'b1 || o_r_inc !== (i == 0 || i == 10)) begin
                bad++;
                $display("FAIL cfg_change cyc %0d: tx=%b busy=%b r_inc=%b, want tx=%b busy=1 r_inc=%b",
                         i, o_tx, o_busy, o_r_inc, exp_tx[i], (i == 0 || i == 10));
            end
            if (i == 3) begin
                i_par_en = 1'b1;
                push(d1);
            end
        end
        @(negedge i_clk);
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || i_empty !== 1'b1) begin
            bad++;
            $display("FAIL cfg_change_idle: tx=%b busy=%b empty=%b, want 1 0 1", o_tx, o_busy, i_empty);
        end
        i_par_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        push(8'h0F);
        for (int i = 0; i < 6; i++) @(negedge i_clk);
        total++;
        if (o_tx !== 1'b0 || o_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_bit4: tx=%b busy=%b, want 0 1", o_tx, o_busy);
        end
        i_rstn = 1'b0;
        #1;
        total++;
        if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_r_inc !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_async: tx=%b busy=%b r_inc=%b, want 1 0 0", o_tx, o_busy, o_r_inc);
        end
        @(negedge i_clk);
        @(negedge i_clk);
        i_rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clk);
            total++;
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_r_inc !== 1'b0 || i_empty !== 1'b1) begin
                bad++;
                $display("FAIL mid_after_release cyc %0d: tx=%b busy=%b r_inc=%b empty=%b, want 1 0 0 1",
                         i, o_tx, o_busy, o_r_inc, i_empty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame(8'hA5, 1'b0, 1'b0, "single_a5");
        test_frame(8'hA5, 1'b1, 1'b0, "parity_even");
        test_frame(8'hA5, 1'b1, 1'b1, "parity_odd");
        test_back_to_back();
        test_cfg_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
